uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Receive-side framing stage; sits directly downstream of the UART byte receiver.
//  Consumes its byte output (din) and byte strobe (sample), hunts for frames, and checks length and checksum.
//  Buffers payload and releases only checksum-good frames on a valid/ready byte stream (out_last marks end).
//  Frame format: SYNC(0xA5), LEN(1..MAX_LEN), LEN payload bytes, CHK = XOR of LEN and all payload bytes.
// PARAMETERS
//  DEPTH          16    payload buffer entries; power of 2, >= MAX_LEN
//  MAX_LEN        8     largest legal LEN value
//  TIMEOUT_CYCLES 2000  inter-byte idle limit in clk cycles (used only with UART_FRAME_TIMEOUT_EN)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  din        in   8  received byte from the UART receiver
//  sample     in   1  byte-valid level from the receiver; held high for several cycles per byte
//  out_data   out  8  payload byte
//  out_last   out  1  out_data is the final byte of its frame
//  out_valid  out  1  out_data/out_last valid
//  out_ready  in   1  consumer accepts the byte when out_valid & out_ready
//  err_chk    out  1  one-cycle pulse: checksum mismatch
//  err_len    out  1  one-cycle pulse: LEN == 0 or LEN > MAX_LEN
//  overflow   out  1  one-cycle pulse: buffer full during payload; frame is dropped
// BEHAVIOUR
//  Reset: all outputs 0; FSM = HUNT; wr/commit/rd pointers = 0; sample_q = 1.
//   sample_q resets to 1 so a sample held high through reset is not taken as a byte.
//  Byte event: sample & ~sample_q. Exactly one event per rising edge of sample, however long sample stays high.
//   din is captured on the event cycle.
//  FSM (advances only on byte events):
//   HUNT -> LEN on din==0xA5; any other byte is ignored.
//   LEN: if 1 <= din <= MAX_LEN, go to PAY; load remaining count = din; chk = din; drop = 0.
//        Otherwise pulse err_len and return to HUNT.
//   PAY: chk ^= din. If not drop and the buffer is not full, write {last,din} at wr_ptr and increment wr_ptr.
//        last = 1 on the final payload byte.
//        If full: set drop, pulse overflow once, discard the rest of the frame.
//        After the final payload byte, go to CHK.
//   CHK: if din==chk and not drop, commit (commit_ptr <= wr_ptr).
//        If din!=chk, pulse err_chk and rewind (wr_ptr <= commit_ptr).
//        If drop, rewind silently.
//        Always return to HUNT.
//  Buffer: pointers are log2(DEPTH)+1 bits.
//   full  = (wr_ptr - rd_ptr) == DEPTH.
//   empty = (rd_ptr == commit_ptr). Only committed bytes are visible.
//   out_valid is registered; a commit appears on out_valid 1 cycle after the CHK event cycle.
//   Pop on out_valid & out_ready; supports back-to-back pops at 1 byte/cycle.
//   Same-cycle pop and speculative write are both honoured. Full is evaluated with the pre-pop rd_ptr.
//  Output hold: out_data/out_last stay stable while out_valid & ~out_ready.
//  0xA5 inside LEN/PAY/CHK is ordinary data; there is no resync mid-frame.
//  Reset mid-frame discards the partial frame and all buffered data, committed or not.
// CONFIGURATION
//  UART_FRAME_TIMEOUT_EN defined:
//   an idle counter clears on every byte event and runs while FSM != HUNT.
//   When it reaches TIMEOUT_CYCLES: rewind wr_ptr to commit_ptr, go to HUNT, pulse err_len.
//  Not defined: no counter. A partial frame waits indefinitely for its remaining bytes.
// STRUCTURE
//  Shared package uart_pkg: SYNC_BYTE = 8'hA5, FSM state encoding (HUNT/LEN/PAY/CHK), byte width constant.
//  One sub-module: uart_frame_fifo.
//   9-bit x DEPTH RAM with wr/commit/rd pointers, commit and rewind inputs, and the registered output stage.
//   The parser FSM, edge detect, checksum and timeout stay in uart_frame_parser.
// TESTING
//  1. Bytes A5,03,11,22,33,03 (chk = 03^11^22^33 = 03), out_ready=1
//     -> out 11,22,33; last=1 only on 33; no error pulses.
//  2. Same frame with CHK = 00 -> err_chk pulses once; out_valid never asserts; next good frame is delivered intact.
//  3. LEN = 00, then separately LEN = MAX_LEN+1 -> err_len pulses once for each; FSM returns to HUNT, no writes.
//  4. DEPTH=16, out_ready=0; send two good 8-byte frames, then a third
//     -> overflow pulses once; raising out_ready yields exactly the first two frames.
//  5. sample held high 50 cycles per byte; reset asserted mid-PAY
//     -> one event per byte; after reset out_valid=0 and the next frame parses normally.
//  6. With UART_FRAME_TIMEOUT_EN: A5,02,11 then idle TIMEOUT_CYCLES
//     -> err_len pulse, rewind; a following good frame is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive-side framing stage.
//   BYTE_W          width of one received byte
//   SYNC_BYTE       start-of-frame marker hunted for between frames
//   parser_state_e  parser FSM encoding (HUNT / LEN / PAY / CHK)
//   FIFO_W          width of one payload buffer entry: {last, byte}
// No ports; imported by uart_frame_fifo and uart_frame_parser.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int FIFO_W = BYTE_W + 1;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        PAY  = 2'd2,
        CHK  = 2'd3
    } parser_state_e;

endpackage

// File: rtl/uart_frame_fifo.sv
// ---------------------------------------------------------------------------
// uart_frame_fifo
// Payload buffer with speculative writes. Bytes are written as they arrive,
// but only become visible to the reader once the frame is committed; a bad
// frame is thrown away by rewinding the write pointer to the commit point.
// Includes the registered output stage that drives the valid/ready stream.
//
// Ports
//   clk          in   1       system clock
//   rst          in   1       synchronous active-high reset
//   wr_en_i      in   1       write wr_data_i at the write pointer
//   wr_data_i    in   9       {last, byte}
//   commit_i     in   1       make everything written so far visible
//   rewind_i     in   1       discard everything written since last commit
//   full_o       out  1       write pointer is DEPTH entries ahead of read
//   out_ready_i  in   1       consumer accepts the current output byte
//   out_data_o   out  8       output byte
//   out_last_o   out  1       output byte ends its frame
//   out_valid_o  out  1       output byte is valid
// ---------------------------------------------------------------------------
module uart_frame_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [FIFO_W-1:0] wr_data_i,
    input  logic              commit_i,
    input  logic              rewind_i,
    output logic              full_o,
    input  logic              out_ready_i,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              out_valid_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [FIFO_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              pop;

    // Full uses the read pointer before this cycle's pop, so a write is only
    // allowed when there is room regardless of what the consumer does.
    assign full_o = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign pop    = out_valid_q & out_ready_i;

    // The output register is a copy of the entry at the next read pointer.
    // Using the next-state commit pointer lets a commit show up on out_valid
    // one cycle after the checksum byte. The slot being written this cycle is
    // never a visible one, so reading the array here is always safe, and while
    // the consumer stalls the same slot is re-read, keeping the output stable.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (rewind_i) begin
            wr_ptr_d = commit_ptr_q;
        end else if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        commit_ptr_d = commit_i ? wr_ptr_q : commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        out_valid_d  = (rd_ptr_d != commit_ptr_d);
        out_d        = out_valid_d ? mem_q[rd_ptr_d[AW-1:0]] : out_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en_i && !rewind_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_data_o  = out_q[BYTE_W-1:0];
    assign out_last_o  = out_q[BYTE_W];
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Receive-side framing stage behind the UART byte receiver. Detects one byte
// per rising edge of 'sample', hunts for SYNC (0xA5), checks LEN and the XOR
// checksum, buffers payload and releases only checksum-good frames on a
// valid/ready byte stream.
// Frame: SYNC, LEN (1..MAX_LEN), LEN payload bytes, CHK = LEN ^ payload.
//
// Optional feature: define UART_FRAME_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYCLES idle clocks (reported on err_len). Without it a
// partial frame waits indefinitely for its remaining bytes.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   din        in   8  received byte
//   sample     in   1  byte-valid level, may stay high for many cycles
//   out_data   out  8  payload byte
//   out_last   out  1  final payload byte of its frame
//   out_valid  out  1  out_data/out_last valid
//   out_ready  in   1  consumer accepts the byte
//   err_chk    out  1  pulse: checksum mismatch
//   err_len    out  1  pulse: illegal LEN (or idle timeout)
//   overflow   out  1  pulse: buffer full during payload, frame dropped
// ---------------------------------------------------------------------------
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int MAX_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] din,
    input  logic              sample,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_chk,
    output logic              err_len,
    output logic              overflow
);

    parser_state_e     state_q, state_d;
    logic              sample_q;
    logic [BYTE_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic              drop_q, drop_d;
    logic              err_chk_q, err_chk_d;
    logic              err_len_q, err_len_d;
    logic              overflow_q, overflow_d;

    logic              byte_evt;
    logic              timeout;
    logic              wr_en;
    logic              wr_last;
    logic              commit;
    logic              rewind;
    logic              fifo_full;

    // sample_q resets high so a sample level held across reset is not
    // mistaken for a fresh byte.
    assign byte_evt = sample & ~sample_q;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;

    // Idle counter: cleared by every byte, only runs while inside a frame.
    always_comb begin
        idle_d = idle_q + TW'(1);
        if (byte_evt || state_q == HUNT) begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign timeout = (state_q != HUNT) && !byte_evt &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Frame FSM. Only byte events move it, except for the optional timeout.
    // Payload is written speculatively; the checksum byte decides whether it
    // is committed or rewound. Once an overflow sets drop, the rest of the
    // frame is swallowed and rewound without a checksum error.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        drop_d     = drop_q;
        wr_en      = 1'b0;
        wr_last    = 1'b0;
        commit     = 1'b0;
        rewind     = 1'b0;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        overflow_d = 1'b0;

        if (byte_evt) begin
            unique case (state_q)
                HUNT: begin
                    if (din == SYNC_BYTE) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (din != '0 && din <= BYTE_W'(MAX_LEN)) begin
                        state_d = PAY;
                        cnt_d   = din;
                        chk_d   = din;
                        drop_d  = 1'b0;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
                PAY: begin
                    chk_d   = chk_q ^ din;
                    wr_last = (cnt_q == BYTE_W'(1));
                    if (!drop_q) begin
                        if (fifo_full) begin
                            drop_d     = 1'b1;
                            overflow_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                    cnt_d = cnt_q - BYTE_W'(1);
                    if (cnt_q == BYTE_W'(1)) begin
                        state_d = CHK;
                    end
                end
                CHK: begin
                    if (drop_q) begin
                        rewind = 1'b1;
                    end else if (din == chk_q) begin
                        commit = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                        rewind    = 1'b1;
                    end
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end else if (timeout) begin
            rewind    = 1'b1;
            err_len_d = 1'b1;
            state_d   = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            sample_q   <= 1'b1;
            cnt_q      <= '0;
            chk_q      <= '0;
            drop_q     <= 1'b0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            drop_q     <= drop_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            overflow_q <= overflow_d;
        end
    end

    assign err_chk  = err_chk_q;
    assign err_len  = err_len_q;
    assign overflow = overflow_q;

    uart_frame_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en),
        .wr_data_i   ({wr_last, din}),
        .commit_i    (commit),
        .rewind_i    (rewind),
        .full_o      (fifo_full),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_valid_o (out_valid)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser
// Directed frames are driven byte by byte; each good frame pushes its
// expected {last, byte} words into a queue, and a monitor pops and compares
// every accepted output byte. Error pulses are counted by the monitor and
// compared against hand-computed totals at checkpoints.
// ---------------------------------------------------------------------------
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       sample;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       err_chk;
    logic       err_len;
    logic       overflow;

    int checks    = 0;
    int failures  = 0;
    int errChkCnt = 0;
    int errLenCnt = 0;
    int ovfCnt    = 0;

    logic [8:0] expQ[$];
    logic [7:0] payBuf[8];

    bit         holdPending = 1'b0;
    logic [8:0] heldWord    = '0;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .DEPTH          (16),
        .MAX_LEN        (8),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sample    (sample),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_chk   (err_chk),
        .err_len   (err_len),
        .overflow  (overflow)
    );

    // Compare one value against its expectation and record the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change just after the rising edge so they are settled for the
    // monitor on the falling edge and for the DUT on the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte with sample held high for 'hold' cycles.
    task automatic applyStimulus(input logic [7:0] b, input int hold);
        din    = b;
        sample = 1'b1;
        repeat (hold) tick();
        sample = 1'b0;
        repeat (2) tick();
    endtask

    // Send SYNC, LEN, payBuf[0..len-1], CHK; queue the payload if it is
    // expected to come out of the DUT.
    task automatic sendFrame(input logic [7:0] len, input logic [7:0] chk,
                             input bit expectOut, input int hold);
        applyStimulus(8'hA5, hold);
        applyStimulus(len, hold);
        for (int i = 0; i < int'(len); i++) begin
            applyStimulus(payBuf[i], hold);
        end
        if (expectOut) begin
            for (int i = 0; i < int'(len); i++) begin
                expQ.push_back({(i == int'(len) - 1), payBuf[i]});
            end
        end
        applyStimulus(chk, hold);
    endtask

    // Wait (bounded) until every queued byte has been seen.
    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput(name, expQ.size(), 0);
        repeat (4) tick();
    endtask

    // Monitor: scoreboard compare on every accepted byte, hold-stability
    // while stalled, and pulse counting.
    always @(negedge clk) begin
        if (rst) begin
            holdPending = 1'b0;
        end else begin
            if (err_chk)  errChkCnt++;
            if (err_len)  errLenCnt++;
            if (overflow) ovfCnt++;
            if (holdPending) begin
                checkOutput("hold_stable", {out_valid, out_last, out_data}, {1'b1, heldWord});
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output actual=0x%0h expected=none",
                             {out_last, out_data});
                end else begin
                    checkOutput("out_byte", {out_last, out_data}, expQ.pop_front());
                end
            end
            holdPending = out_valid && !out_ready;
            heldWord    = {out_last, out_data};
        end
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        din       = 8'h00;
        sample    = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("reset_outputs",
                    {out_valid, out_last, out_data, err_chk, err_len, overflow}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: good frame, checksum 03^11^22^33 = 03
        $display("[TB] test 1: good 3-byte frame");
        payBuf[0] = 8'h11; payBuf[1] = 8'h22; payBuf[2] = 8'h33;
        sendFrame(8'h03, 8'h03, 1'b1, 3);
        waitDrain("t1_drain");
        checkOutput("t1_err_chk", errChkCnt, 0);
        checkOutput("t1_err_len", errLenCnt, 0);
        checkOutput("t1_overflow", ovfCnt, 0);

        // 2: bad checksum, then the same frame with the right checksum
        $display("[TB] test 2: bad checksum then good frame");
        sendFrame(8'h03, 8'h00, 1'b0, 3);
        repeat (4) tick();
        checkOutput("t2_err_chk_once", errChkCnt, 1);
        sendFrame(8'h03, 8'h03, 1'b1, 3);
        waitDrain("t2_drain");
        checkOutput("t2_err_chk_total", errChkCnt, 1);

        // 3: LEN = 0 and LEN = MAX_LEN+1, then a frame carrying 0xA5 as data
        $display("[TB] test 3: illegal LEN values");
        applyStimulus(8'hA5, 3);
        applyStimulus(8'h00, 3);
        repeat (2) tick();
        checkOutput("t3_len_zero", errLenCnt, 1);
        applyStimulus(8'hA5, 3);
        applyStimulus(8'h09, 3);
        repeat (2) tick();
        checkOutput("t3_len_big", errLenCnt, 2);
        payBuf[0] = 8'hA5; payBuf[1] = 8'hA5;
        sendFrame(8'h02, 8'h02, 1'b1, 3);
        waitDrain("t3_drain");
        checkOutput("t3_err_len_total", errLenCnt, 2);

        // 4: fill the 16-entry buffer with two 8-byte frames, third overflows
        $display("[TB] test 4: overflow with consumer stalled");
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) payBuf[i] = 8'(8'h01 + i);
        sendFrame(8'h08, 8'h00, 1'b1, 3);
        for (int i = 0; i < 8; i++) payBuf[i] = 8'(8'h10 + i);
        sendFrame(8'h08, 8'h08, 1'b1, 3);
        for (int i = 0; i < 8; i++) payBuf[i] = 8'(8'h20 + i);
        sendFrame(8'h08, 8'h08, 1'b0, 3);
        repeat (3) tick();
        checkOutput("t4_overflow_once", ovfCnt, 1);
        checkOutput("t4_no_err_chk", errChkCnt, 1);
        checkOutput("t4_head_held", {out_valid, out_last, out_data}, {2'b10, 8'h01});
        out_ready = 1'b1;
        waitDrain("t4_drain");
        checkOutput("t4_overflow_total", ovfCnt, 1);

        // 5: long sample pulses, reset mid-payload with sample held high
        $display("[TB] test 5: long sample and reset mid-frame");
        out_ready = 1'b0;
        payBuf[0] = 8'h77;
        sendFrame(8'h01, 8'h76, 1'b0, 50);
        applyStimulus(8'hA5, 50);
        applyStimulus(8'h04, 50);
        applyStimulus(8'h11, 50);
        applyStimulus(8'h22, 50);
        din    = 8'hA5;
        sample = 1'b1;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        expQ.delete();
        rst = 1'b0;
        tick();
        checkOutput("t5_valid_after_reset", out_valid, 0);
        repeat (20) tick();
        sample    = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        checkOutput("t5_still_empty", out_valid, 0);
        payBuf[0] = 8'hAA; payBuf[1] = 8'hBB;
        sendFrame(8'h02, 8'h13, 1'b1, 50);
        waitDrain("t5_drain");
        checkOutput("t5_no_len_err", errLenCnt, 2);
        checkOutput("t5_no_chk_err", errChkCnt, 1);

`ifdef UART_FRAME_TIMEOUT_EN
        // 6: partial frame abandoned after the idle limit
        $display("[TB] test 6: idle timeout");
        applyStimulus(8'hA5, 3);
        applyStimulus(8'h02, 3);
        applyStimulus(8'h11, 3);
        repeat (2010) tick();
        checkOutput("t6_timeout_err_len", errLenCnt, 3);
        payBuf[0] = 8'h44; payBuf[1] = 8'h55;
        sendFrame(8'h02, 8'h13, 1'b1, 3);
        waitDrain("t6_drain");
`endif

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
